// File: rtl/spi_peripheral_if.sv
// SPI pin bundle between an external controller and the register target.
// Write-only link: there is no CIPO line.
interface spi_peripheral_if;
    logic sclk;
    logic copi;
    logic ncs;

    modport master (output sclk, output copi, output ncs);
    modport slave  (input  sclk, input  copi, input  ncs);
endinterface

// File: rtl/spi_peripheral.sv
// Mode-0 SPI write target holding the five 8-bit PWM control registers.
// The SPI pins are oversampled by clk. Each 16-bit frame is {rw, addr[6:0], data[7:0]}, sent MSB first.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | ncs high, bit counter held at 0
// ST_SHIFT  | ncs low, sclk rising edges shift copi in and are counted
// ST_COMMIT | single cycle after the ncs rise; the frame has been judged
module spi_peripheral #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [6:0] MAX_ADDR    = 7'h04
) (
    input  logic                   clk,
    input  logic                   rst_n,
    spi_peripheral_if.slave        spi,
    output logic [7:0]             en_reg_out_7_0,
    output logic [7:0]             en_reg_out_15_8,
    output logic [7:0]             en_reg_pwm_7_0,
    output logic [7:0]             en_reg_pwm_15_8,
    output logic [7:0]             pwm_duty_cycle
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync, copi_sync, ncs_sync;
    logic                   sclk_d, copi_d, ncs_d;
    logic                   sclk_s, copi_s, ncs_s;
    logic                   sclk_rise, ncs_rise;

    logic [15:0] shift_q;
    logic [4:0]  bit_cnt_q;
    logic        frame_ok;
    logic        wr_en;

    logic [7:0] out_lo_q, out_hi_q, pwm_lo_q, pwm_hi_q, duty_q;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign copi_s = copi_sync[SYNC_STAGES-1];
    assign ncs_s  = ncs_sync[SYNC_STAGES-1];

    // Sclk edges inside the ncs-rise cycle are ignored because ncs_s is already high.
    assign sclk_rise = sclk_s & ~sclk_d & ~ncs_s;
    assign ncs_rise  = ncs_s & ~ncs_d;

    // Synchronize the SPI pins, then add one delay flop per pin for edge detection and alignment.
    // ncs resets high so that an idle bus does not look like an open frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            copi_sync <= '0;
            ncs_sync  <= '1;
            sclk_d    <= 1'b0;
            copi_d    <= 1'b0;
            ncs_d     <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.sclk};
            copi_sync <= {copi_sync[SYNC_STAGES-2:0], spi.copi};
            ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], spi.ncs};
            sclk_d    <= sclk_s;
            copi_d    <= copi_s;
            ncs_d     <= ncs_s;
        end
    end

    // Shift copi in MSB first, and count bits with saturation so that long frames never wrap back to 16.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            if (sclk_rise) begin
                shift_q <= {shift_q[14:0], copi_d};
            end
            if (ncs_s) begin
                bit_cnt_q <= '0;
            end else if (sclk_rise && (bit_cnt_q != 5'd31)) begin
                bit_cnt_q <= bit_cnt_q + 5'd1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (!ncs_s)   state_d = ST_SHIFT;
            ST_SHIFT:  if (ncs_rise) state_d = ST_COMMIT;
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Judge the frame on the ncs rise. The bit count is still valid in this cycle.
    assign frame_ok = (bit_cnt_q == 5'd16) && shift_q[15] && (shift_q[14:8] <= MAX_ADDR);

    // Output logic: raise the write strobe on the edge that enters ST_COMMIT, keeping latency at SYNC_STAGES+1 edges.
    always_comb begin
        wr_en = 1'b0;
        if ((state_q == ST_SHIFT) && ncs_rise && frame_ok) begin
            wr_en = 1'b1;
        end
    end

    // Register file: only the addressed register updates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_lo_q <= '0;
            out_hi_q <= '0;
            pwm_lo_q <= '0;
            pwm_hi_q <= '0;
            duty_q   <= '0;
        end else if (wr_en) begin
            case (shift_q[14:8])
                7'h00:   out_lo_q <= shift_q[7:0];
                7'h01:   out_hi_q <= shift_q[7:0];
                7'h02:   pwm_lo_q <= shift_q[7:0];
                7'h03:   pwm_hi_q <= shift_q[7:0];
                7'h04:   duty_q   <= shift_q[7:0];
                default: ;
            endcase
        end
    end

    assign en_reg_out_7_0  = out_lo_q;
    assign en_reg_out_15_8 = out_hi_q;
    assign en_reg_pwm_7_0  = pwm_lo_q;
    assign en_reg_pwm_15_8 = pwm_hi_q;
    assign pwm_duty_cycle  = duty_q;

endmodule

// File: tb/tb_spi_peripheral.sv
// Self-checking bench for spi_peripheral.
// A reference model predicts register writes and queues them. A monitor pops one entry for each register change it observes.
module tb_spi_peripheral;

    localparam int HALF = 4;   // sclk half period in clk cycles, f_sclk = f_clk/8
    localparam int GAP  = 4;   // minimum ncs-high time between frames

    typedef struct packed {
        logic [2:0] addr;
        logic [7:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [7:0] o0, o1, o2, o3, o4;

    spi_peripheral_if spi ();

    spi_peripheral dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .spi             (spi),
        .en_reg_out_7_0  (o0),
        .en_reg_out_15_8 (o1),
        .en_reg_pwm_7_0  (o2),
        .en_reg_pwm_15_8 (o3),
        .pwm_duty_cycle  (o4)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    wr_t        sb_q[$];
    wr_t        mon_e;
    logic [7:0] exp_regs  [5];
    logic [7:0] prev_regs [5];

    function automatic logic [7:0] obs(input int i);
        case (i)
            0:       return o0;
            1:       return o1;
            2:       return o2;
            3:       return o3;
            default: return o4;
        endcase
    endfunction

    // Monitor: every register change must match the next queued write.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 5; i++) prev_regs[i] = obs(i);
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (obs(i) !== prev_regs[i]) begin
                    n_checks++;
                    if (sb_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_write: reg%0d changed to %02h, no write expected", i, obs(i));
                    end else begin
                        mon_e = sb_q.pop_front();
                        if ((mon_e.addr != 3'(i)) || (mon_e.data !== obs(i))) begin
                            n_fail++;
                            $display("FAIL sb_write: got reg%0d=%02h, expected reg%0d=%02h",
                                     i, obs(i), mon_e.addr, mon_e.data);
                        end
                    end
                    prev_regs[i] = obs(i);
                end
            end
        end
    end

    // Watchdog against a hung run.
    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    // Reference model: decide acceptance and queue the expected register change.
    task automatic sb_frame(input logic [31:0] val, input int n);
        logic [6:0] a;
        logic [7:0] d;
        a = val[14:8];
        d = val[7:0];
        if (n == 16 && val[15] && a <= 7'h04) begin
            if (exp_regs[a[2:0]] !== d) sb_q.push_back('{addr: a[2:0], data: d});
            exp_regs[a[2:0]] = d;
        end
    endtask

    task automatic cs_low();
        spi.ncs = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic send_bits(input logic [31:0] val, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            spi.copi = val[i];
            repeat (HALF) @(negedge clk);
            spi.sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            spi.sclk = 1'b0;
        end
    endtask

    task automatic frame(input logic [31:0] val, input int n, input int gap);
        cs_low();
        send_bits(val, n);
        repeat (HALF) @(negedge clk);
        sb_frame(val, n);
        spi.ncs = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (obs(i) !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_held: reg%0d got %02h expected 00", i, obs(i));
            end
        end
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (obs(i) !== exp_regs[i]) begin
                n_fail++;
                $display("FAIL reset_idle: reg%0d got %02h expected %02h", i, obs(i), exp_regs[i]);
            end
        end
    endtask

    task automatic test_valid_writes();
        cs_low();
        send_bits(32'h80FF, 16);
        repeat (HALF) @(negedge clk);
        sb_frame(32'h80FF, 16);
        spi.ncs = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (o0 !== 8'h00) begin
            n_fail++;
            $display("FAIL latency_early: en_reg_out_7_0 got %02h expected 00 at 2nd edge", o0);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (o0 !== 8'hFF) begin
            n_fail++;
            $display("FAIL latency_3rd_edge: en_reg_out_7_0 got %02h expected ff", o0);
        end
        repeat (10) @(negedge clk);
        frame(32'h8480, 16, 10);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (obs(i) !== exp_regs[i]) begin
                n_fail++;
                $display("FAIL valid_writes: reg%0d got %02h expected %02h", i, obs(i), exp_regs[i]);
            end
        end
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL valid_drain: %0d writes outstanding, expected 0", sb_q.size());
        end
    endtask

    task automatic test_rejected();
        frame(32'h00AA, 16, 10);
        frame(32'h85AA, 16, 10);
        frame(32'hFFAA, 16, 10);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (obs(i) !== exp_regs[i]) begin
                n_fail++;
                $display("FAIL rejected: reg%0d got %02h expected %02h", i, obs(i), exp_regs[i]);
            end
        end
    endtask

    task automatic test_frame_length();
        frame(32'h8155 >> 1, 15, 10);
        frame({15'h0, 16'h8155, 1'b0}, 17, 10);
        n_checks++;
        if (o1 !== 8'h00) begin
            n_fail++;
            $display("FAIL short_long_frame: en_reg_out_15_8 got %02h expected 00", o1);
        end
        frame(32'h8155, 16, 10);
        n_checks++;
        if (o1 !== 8'h55) begin
            n_fail++;
            $display("FAIL exact_frame: en_reg_out_15_8 got %02h expected 55", o1);
        end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (obs(i) !== exp_regs[i]) begin
                n_fail++;
                $display("FAIL frame_length: reg%0d got %02h expected %02h", i, obs(i), exp_regs[i]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        frame(32'h8211, 16, 10);
        n_checks++;
        if (o2 !== 8'h11) begin
            n_fail++;
            $display("FAIL pre_reset_write: en_reg_pwm_7_0 got %02h expected 11", o2);
        end
        cs_low();
        send_bits(32'h82, 8);
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) exp_regs[i] = 8'h00;
        #1;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (obs(i) !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_mid_frame: reg%0d got %02h expected 00", i, obs(i));
            end
        end
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        send_bits(32'h33, 8);
        repeat (HALF) @(negedge clk);
        sb_frame(32'h33, 8);
        spi.ncs = 1'b1;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (obs(i) !== exp_regs[i]) begin
                n_fail++;
                $display("FAIL reset_tail_frame: reg%0d got %02h expected %02h", i, obs(i), exp_regs[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 5; k++) begin
            frame({16'h0, 1'b1, 7'(k), 8'(k + 1)}, 16, GAP);
        end
        repeat (10) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (obs(i) !== 8'(i + 1)) begin
                n_fail++;
                $display("FAIL back_to_back: reg%0d got %02h expected %02h", i, obs(i), 8'(i + 1));
            end
        end
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL back_to_back_drain: %0d writes outstanding, expected 0", sb_q.size());
        end
    endtask

    initial begin
        spi.sclk = 1'b0;
        spi.copi = 1'b0;
        spi.ncs  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_regs[i]  = 8'h00;
            prev_regs[i] = 8'h00;
        end
        test_reset();
        test_valid_writes();
        test_rejected();
        test_frame_length();
        test_reset_mid_frame();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_peripheral.md
# spi_peripheral

SPI target (mode 0) that receives 16-bit write transactions from an external controller and holds the five 8-bit control registers driving the PWM peripheral: output enables, PWM enables and the shared duty cycle. It sits directly upstream of the PWM peripheral inside the Tiny Tapeout top level. Its SPI pins come from ui_in[0] (SCLK), ui_in[1] (COPI) and ui_in[2] (nCS), and its register outputs connect one-to-one to the PWM peripheral's register inputs. Write-only: there is no read-back path and no CIPO.

## Interface
Parameters:
- SYNC_STAGES, 2: flip-flop depth of each input synchronizer (≥2).
- MAX_ADDR, 7'h04: highest valid register address.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  reset, asynchronous and active-low; clears all state.
- sclk  input  1  SPI clock, asynchronous to clk.
- copi  input  1  SPI data, controller to peripheral.
- ncs  input  1  SPI chip select, active-low.
- en_reg_out_7_0  output  8  address 0x00, output enables for bits 7:0.
- en_reg_out_15_8  output  8  address 0x01, output enables for bits 15:8.
- en_reg_pwm_7_0  output  8  address 0x02, PWM mode enables for bits 7:0.
- en_reg_pwm_15_8  output  8  address 0x03, PWM mode enables for bits 15:8.
- pwm_duty_cycle  output  8  address 0x04, duty cycle (0x00 = 0%, 0xFF = 100%).

## Operation
- Each of sclk, copi and ncs passes through a SYNC_STAGES-deep synchronizer. One extra delay flop on sclk and ncs provides edge detection. The delay flop on copi keeps copi aligned with sclk.
- SCLK rising edge: synchronized sclk is 1 and its delayed copy is 0. A rising edge counts only while synchronized ncs is 0.
- On each counted edge:
  - shift synchronized copi into a 16-bit shift register, MSB first;
  - increment a 5-bit bit counter that saturates at 31.
- Frame layout:
  - bit 15: R/W (1 = write);
  - bits 14:8: address;
  - bits 7:0: data.
- While synchronized ncs is 1, the bit counter is held at 0. The shift register keeps its contents.
- Commit happens on the ncs rising edge (synchronized ncs 1, delayed copy 0). The frame is accepted only if all of the following hold:
  - bit count == 16;
  - bit 15 == 1;
  - address ≤ MAX_ADDR.
- An accepted frame writes the data byte into the addressed register. All other frames are discarded with no register change:
  - reads;
  - short frames (<16 bits);
  - long frames (>16 bits);
  - out-of-range addresses.
- Registers hold their value indefinitely until the next accepted write.
- State machine: IDLE (ncs high, counter 0) → SHIFT (ncs low, counting) → COMMIT (single cycle on ncs rise) → IDLE. Reset forces IDLE.

## Timing
- Reset value of all five register outputs, the shift register and the bit counter: 0x00. Reset applies asynchronously on rst_n fall and is released synchronously with clk.
- Reset asserted mid-frame: the partial frame is lost and the registers read 0.
  - If ncs is still low when reset releases, the remaining bits are counted as a new frame. That frame has fewer than 16 bits, so it is discarded.
- Latency: a register changes on the (SYNC_STAGES+1)th rising clk edge after raw ncs rises. With the default this is the 3rd edge, ±1 edge for synchronizer uncertainty.
- SCLK constraints:
  - SCLK high time and low time each ≥ SYNC_STAGES+1 clk periods, i.e. f_clk ≥ 6 × f_sclk with the default.
  - COPI stable ≥ 1 clk period before and after each SCLK rise.
- The last SCLK rising edge must precede the ncs rise by ≥ 2 clk periods. An SCLK rise detected in the same cycle as the ncs rise is ignored.
- Back-to-back frames: ncs high for ≥ SYNC_STAGES+2 clk periods between frames. Each frame commits independently.
- Only the addressed register updates on a commit. The other four are untouched in that cycle.

## Test plan
- Reset: hold rst_n low for 5 clk, release → all five outputs 0x00; no change while ncs stays high.
- Valid writes: frame 0x80FF (write, addr 0x00, data 0xFF) → en_reg_out_7_0 = 0xFF at the 3rd clk edge after ncs rise, others 0x00. Then frame 0x8480 → pwm_duty_cycle = 0x80, en_reg_out_7_0 still 0xFF.
- Rejected frames: frame 0x00AA (read), then 0x85AA (addr 0x05), then 0xFFAA (addr 0x7F) → all registers unchanged.
- Frame length: 15-bit frame carrying 0x8155 and 17-bit frame 0x8155 followed by one extra bit → en_reg_out_15_8 unchanged. A following correct 16-bit 0x8155 → en_reg_out_15_8 = 0x55.
- Reset mid-frame: assert rst_n after 8 bits of 0x8233 with en_reg_pwm_7_0 previously 0x11 → en_reg_pwm_7_0 = 0x00 immediately; finishing the frame after release produces no write.
- Back-to-back writes: five consecutive frames to addresses 0x00–0x04 at f_sclk = f_clk/8, minimum ncs gap → registers read 0x01, 0x02, 0x03, 0x04, 0x05.
